// File: rtl/exc_pkg.sv
// Shared definitions for the exception pipeline registers: default code
// width, the MIPS ExcCode values used by the stages, and a helper that
// sizes the winner index of the fixed-priority encoder.
package exc_pkg;

  localparam int EXC_W_DEF = 5;

  typedef logic [EXC_W_DEF-1:0] exc_code_t;

  // MIPS ExcCode values
  localparam exc_code_t EXC_INT  = 5'd0;
  localparam exc_code_t EXC_ADEL = 5'd4;
  localparam exc_code_t EXC_ADES = 5'd5;
  localparam exc_code_t EXC_RI   = 5'd10;
  localparam exc_code_t EXC_OV   = 5'd12;

  // Width of an index over n sources (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder over NUM_SRC exception requests. Source 0 has the
// highest priority. Outputs whether any request is set, the index of the
// winning source and that source's exception code. Purely combinational.
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int EXC_W   = EXC_W_DEF,
  parameter int IDX_W   = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC*EXC_W-1:0] codes,
  output logic                     any,
  output logic [IDX_W-1:0]         idx,
  output logic [EXC_W-1:0]         code
);

  // Scan from the lowest-priority source upward so the lowest asserted
  // index is the last one written and therefore wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    code = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req[k]) begin
        any  = 1'b1;
        idx  = IDX_W'(k);
        code = codes[k*EXC_W +: EXC_W];
      end
    end
  end

endmodule

// File: rtl/exc_stage_reg.sv
// Exception pipeline register placed between two MIPS stages (E->M, M->W).
//
// The exception carried in from the upstream stage is merged with up to
// NUM_SRC locally raised sources. An upstream exception always wins (it
// belongs to the older instruction); otherwise the lowest-index local
// request wins. The merged result, PC and delay-slot flag are registered.
//
// Handshake: valid_o qualifies pc_o, bd_o, exc_o, exc_code_o (and
// bad_addr_o). There is no ready; downstream backpressure arrives as
// stall_i, which holds every registered output. flush_i inserts a bubble
// and overrides stall_i. A bubble never carries an exception.
//
// exc_new_o pulses for one cycle after an exception is loaded, and
// exc_cnt_o counts those pulses, saturating at its all-ones value.
//
// Optional build macro EXC_BADVADDR_EN adds bad_addr_i / src_addr_i
// inputs and a registered bad_addr_o that follows the winning source.
module exc_stage_reg
  import exc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int EXC_W   = EXC_W_DEF,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic                     bd_i,
  input  logic                     exc_i,
  input  logic [EXC_W-1:0]         exc_code_i,
  input  logic [NUM_SRC-1:0]       src_req_i,
  input  logic [NUM_SRC*EXC_W-1:0] src_code_i,
`ifdef EXC_BADVADDR_EN
  input  logic [PC_W-1:0]          bad_addr_i,
  input  logic [NUM_SRC*PC_W-1:0]  src_addr_i,
  output logic [PC_W-1:0]          bad_addr_o,
`endif
  output logic                     valid_o,
  output logic [PC_W-1:0]          pc_o,
  output logic                     bd_o,
  output logic                     exc_o,
  output logic [EXC_W-1:0]         exc_code_o,
  output logic                     exc_new_o,
  output logic [CNT_W-1:0]         exc_cnt_o
);

  localparam int               IDX_W   = idx_width(NUM_SRC);
  localparam logic [EXC_W-1:0] NO_EXC  = EXC_W'(EXC_INT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Local source arbitration
  logic             enc_any;
  logic [IDX_W-1:0] win_idx;
  logic [EXC_W-1:0] enc_code;

  // Merged result presented to the register
  logic             merged_exc;
  logic [EXC_W-1:0] merged_code;

  exc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .EXC_W   (EXC_W),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .req   (src_req_i),
    .codes (src_code_i),
    .any   (enc_any),
    .idx   (win_idx),
    .code  (enc_code)
  );

  // Encoder consistency: the reported winner is an asserted request and
  // the reported code is that source's code.
  always_comb begin : prio_check
    if (enc_any) begin
      assert (src_req_i[win_idx]);
      assert (enc_code == src_code_i[win_idx*EXC_W +: EXC_W]);
    end
  end

  // Merge upstream and local exceptions; a bubble carries none.
  always_comb begin
    merged_exc  = valid_i & (exc_i | enc_any);
    merged_code = NO_EXC;
    if (valid_i) begin
      if (exc_i) begin
        merged_code = exc_code_i;
      end else if (enc_any) begin
        merged_code = enc_code;
      end
    end
  end

`ifdef EXC_BADVADDR_EN
  logic [PC_W-1:0] merged_addr;

  // Faulting address follows whichever exception won the merge.
  always_comb begin
    merged_addr = '0;
    if (valid_i) begin
      if (exc_i) begin
        merged_addr = bad_addr_i;
      end else if (enc_any) begin
        merged_addr = src_addr_i[win_idx*PC_W +: PC_W];
      end
    end
  end

  // BadVAddr register: cleared by flush, held by stall, loaded otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bad_addr_o <= '0;
    end else if (flush_i) begin
      bad_addr_o <= '0;
    end else if (!stall_i) begin
      bad_addr_o <= merged_addr;
    end
  end
`endif

  // Stage payload: flush loads a bubble, stall holds, otherwise load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      bd_o       <= 1'b0;
      exc_o      <= 1'b0;
      exc_code_o <= NO_EXC;
    end else if (flush_i) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      bd_o       <= 1'b0;
      exc_o      <= 1'b0;
      exc_code_o <= NO_EXC;
    end else if (!stall_i) begin
      valid_o    <= valid_i;
      pc_o       <= pc_i;
      bd_o       <= bd_i;
      exc_o      <= merged_exc;
      exc_code_o <= merged_code;
    end
  end

  // New-exception pulse and saturating counter, both updated on a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exc_new_o <= 1'b0;
      exc_cnt_o <= '0;
    end else if (flush_i || stall_i) begin
      exc_new_o <= 1'b0;
    end else begin
      exc_new_o <= merged_exc;
      if (merged_exc && (exc_cnt_o != CNT_MAX)) begin
        exc_cnt_o <= exc_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_exc_stage_reg.sv
// Bench for exc_stage_reg: directed scenarios followed by randomized
// traffic. A driver applies inputs on the falling edge and pushes the
// reference model's expected outputs into exp_q; a monitor pops and
// compares one entry after every rising edge that has work queued.
module tb_exc_stage_reg;
  import exc_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int EXC_W   = 5;
  localparam int PC_W    = 32;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int OUT_W   = 1 + PC_W + 1 + 1 + EXC_W + 1 + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic                     stall_i, flush_i, valid_i, bd_i, exc_i;
  logic [PC_W-1:0]          pc_i;
  logic [EXC_W-1:0]         exc_code_i;
  logic [NUM_SRC-1:0]       src_req_i;
  logic [NUM_SRC*EXC_W-1:0] src_code_i;
  logic                     valid_o, bd_o, exc_o, exc_new_o;
  logic [PC_W-1:0]          pc_o;
  logic [EXC_W-1:0]         exc_code_o;
  logic [CNT_W-1:0]         exc_cnt_o;
`ifdef EXC_BADVADDR_EN
  logic [PC_W-1:0]          bad_addr_i, bad_addr_o;
  logic [NUM_SRC*PC_W-1:0]  src_addr_i;
  logic [PC_W-1:0]          ba_q[$];
  logic [PC_W-1:0]          m_ba;
`endif

  exc_stage_reg #(
    .NUM_SRC (NUM_SRC),
    .EXC_W   (EXC_W),
    .PC_W    (PC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .pc_i       (pc_i),
    .bd_i       (bd_i),
    .exc_i      (exc_i),
    .exc_code_i (exc_code_i),
    .src_req_i  (src_req_i),
    .src_code_i (src_code_i),
`ifdef EXC_BADVADDR_EN
    .bad_addr_i (bad_addr_i),
    .src_addr_i (src_addr_i),
    .bad_addr_o (bad_addr_o),
`endif
    .valid_o    (valid_o),
    .pc_o       (pc_o),
    .bd_o       (bd_o),
    .exc_o      (exc_o),
    .exc_code_o (exc_code_o),
    .exc_new_o  (exc_new_o),
    .exc_cnt_o  (exc_cnt_o)
  );

  // ---------------- scoreboard state ----------------
  logic [OUT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_cycle  = 0;

  // Reference model: the architectural contents of the stage
  logic             m_valid, m_bd, m_exc, m_new;
  logic [PC_W-1:0]  m_pc;
  logic [EXC_W-1:0] m_code;
  int               m_cnt;

  function automatic logic [OUT_W-1:0] pack_dut();
    return {valid_o, pc_o, bd_o, exc_o, exc_code_o, exc_new_o, exc_cnt_o};
  endfunction

  function automatic logic [OUT_W-1:0] pack_model();
    return {m_valid, m_pc, m_bd, m_exc, m_code, m_new, CNT_W'(m_cnt)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_valid = 0; m_bd = 0; m_exc = 0; m_new = 0; m_pc = '0; m_code = '0; m_cnt = 0;
`ifdef EXC_BADVADDR_EN
    m_ba = '0;
`endif
  endtask

  // One clock of architectural behaviour, from the current inputs.
  task automatic model_step();
    int win;
    logic has;
    win = -1;
    if (exc_i) win = NUM_SRC;
    else for (int k = 0; k < NUM_SRC; k++) if (src_req_i[k] && win < 0) win = k;
    has = valid_i && (win >= 0);
    if (flush_i) begin
      m_valid = 0; m_pc = '0; m_bd = 0; m_exc = 0; m_code = '0; m_new = 0;
`ifdef EXC_BADVADDR_EN
      m_ba = '0;
`endif
    end else if (stall_i) begin
      m_new = 0;
    end else begin
      m_valid = valid_i;
      m_pc    = pc_i;
      m_bd    = bd_i;
      m_exc   = has;
      m_new   = has;
      m_code  = !has ? '0 : (win == NUM_SRC) ? exc_code_i : src_code_i[win*EXC_W +: EXC_W];
      if (has) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
`ifdef EXC_BADVADDR_EN
      m_ba = !has ? '0 : (win == NUM_SRC) ? bad_addr_i : src_addr_i[win*PC_W +: PC_W];
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic fl, input logic vl, input logic [PC_W-1:0] pc,
                       input logic bd, input logic ex, input logic [EXC_W-1:0] ec,
                       input logic [NUM_SRC-1:0] req, input logic [NUM_SRC*EXC_W-1:0] codes);
    @(negedge clk);
    reset_n    = 1'b1;
    stall_i    = st;
    flush_i    = fl;
    valid_i    = vl;
    pc_i       = pc;
    bd_i       = bd;
    exc_i      = ex;
    exc_code_i = ec;
    src_req_i  = req;
    src_code_i = codes;
`ifdef EXC_BADVADDR_EN
    bad_addr_i = $urandom;
    src_addr_i = {$urandom, $urandom, $urandom, $urandom};
`endif
    model_step();
    exp_q.push_back(pack_model());
`ifdef EXC_BADVADDR_EN
    ba_q.push_back(m_ba);
`endif
  endtask

  task automatic drive_rand(input int p_stall, input int p_flush);
    drive($urandom_range(99) < p_stall, $urandom_range(99) < p_flush,
          $urandom_range(99) < 80, $urandom, 1'($urandom),
          $urandom_range(99) < 20, 5'($urandom),
          ($urandom_range(99) < 40) ? 4'b0 : 4'($urandom),
          {5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)});
  endtask

  // Wait until just after the rising edge that consumed the last drive.
  task automatic post();
    @(posedge clk);
    #2;
  endtask

  // Assert reset in the middle of a cycle with random inputs; outputs
  // must clear without waiting for a clock edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    stall_i = 1'($urandom); flush_i = 1'($urandom); valid_i = 1'($urandom);
    pc_i = $urandom; bd_i = 1'($urandom); exc_i = 1'($urandom);
    exc_code_i = 5'($urandom); src_req_i = 4'($urandom);
    src_code_i = {5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)};
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'(pack_dut()), 64'd0);
`ifdef EXC_BADVADDR_EN
    check("async_reset_bad_addr", 64'(bad_addr_o), 64'd0);
`endif
    model_reset();
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OUT_W-1:0] exp_v;
      #1;
      exp_v = exp_q.pop_front();
      n_cycle++;
      n_checks++;
      if (pack_dut() === exp_v) n_pass++;
      else $display("FAIL scoreboard cycle %0d: got %h expected %h", n_cycle, pack_dut(), exp_v);
`ifdef EXC_BADVADDR_EN
      begin
        logic [PC_W-1:0] exp_ba;
        exp_ba = ba_q.pop_front();
        n_checks++;
        if (bad_addr_o === exp_ba) n_pass++;
        else $display("FAIL bad_addr cycle %0d: got %h expected %h", n_cycle, bad_addr_o, exp_ba);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  int exp_cnt_seq[5] = '{1, 2, 3, 3, 3};

  initial begin
    reset_n = 1'b0;
    stall_i = 0; flush_i = 0; valid_i = 0; pc_i = '0; bd_i = 0; exc_i = 0;
    exc_code_i = '0; src_req_i = '0; src_code_i = '0;
`ifdef EXC_BADVADDR_EN
    bad_addr_i = '0; src_addr_i = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 64'(pack_dut()), 64'd0);

    // Local sources 1 and 2 raised: source 1 wins
    drive(0, 0, 1, 32'h0000_3000, 0, 0, 5'd0, 4'b0110, {EXC_OV, EXC_RI, EXC_ADES, EXC_ADEL});
    post();
    check("src1_code", 64'(exc_code_o), 64'd5);
    check("src1_new", 64'(exc_new_o), 64'd1);
    check("src1_cnt", 64'(exc_cnt_o), 64'd1);
    drive(0, 0, 1, 32'h0000_3004, 0, 0, 5'd0, 4'b0000, '0);
    post();
    check("pulse_one_cycle", 64'(exc_new_o), 64'd0);

    // Upstream exception beats local source 0, then hold for 3 cycles
    drive(0, 0, 1, 32'h0000_3008, 1, 1, EXC_RI, 4'b0001, {15'd0, EXC_OV});
    post();
    check("upstream_code", 64'(exc_code_o), 64'd10);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, $urandom, 1'($urandom), 1, 5'($urandom), 4'b1111, 20'($urandom));
      post();
      check("stall_code", 64'(exc_code_o), 64'd10);
      check("stall_new", 64'(exc_new_o), 64'd0);
      check("stall_cnt", 64'(exc_cnt_o), 64'd2);
    end

    // Load exception 12, then stall and flush together
    drive(0, 0, 1, 32'h0000_300c, 0, 0, 5'd0, 4'b0100, {5'd0, EXC_OV, 10'd0});
    post();
    check("ov_code", 64'(exc_code_o), 64'd12);
    drive(1, 1, 1, $urandom, 1, 1, EXC_RI, 4'b0001, 20'($urandom));
    post();
    check("flush_valid", 64'(valid_o), 64'd0);
    check("flush_exc", 64'(exc_o), 64'd0);
    check("flush_code", 64'(exc_code_o), 64'd0);

    // Local request on a bubble is ignored
    drive(0, 0, 0, 32'h0000_3010, 0, 0, 5'd0, 4'b1000, {EXC_OV, 15'd0});
    post();
    check("bubble_exc", 64'(exc_o), 64'd0);
    check("bubble_cnt", 64'(exc_cnt_o), 64'd3);

    // Saturation from a fresh counter: 1, 2, 3, 3, 3
    async_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 32'h0000_4000 + 32'(4 * i), 0, 1, EXC_ADEL, 4'($urandom), 20'($urandom));
      post();
      check("sat_cnt", 64'(exc_cnt_o), 64'(exp_cnt_seq[i]));
      check("sat_new", 64'(exc_new_o), 64'd1);
    end

    // Reset arriving in the middle of a stall
    drive(1, 0, 1, $urandom, 0, 1, EXC_OV, 4'b0, '0);
    drive(1, 0, 1, $urandom, 0, 1, EXC_OV, 4'b0, '0);
    async_reset();

    // Randomized traffic, with a mid-run reset
    repeat (300) drive_rand(25, 10);
    async_reset();
    repeat (200) drive_rand(15, 5);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
